// File: rtl/rom_req_sched_pkg.sv
// Shared types and helpers for the ROM request scheduler.
package rom_req_sched_pkg;

  typedef logic [1:0] dem_state_t;

  localparam dem_state_t ST_IDLE = 2'd0;
  localparam dem_state_t ST_PEND = 2'd1;
  localparam dem_state_t ST_WAIT = 2'd2;

  function automatic int unsigned slot_w(input int unsigned slots);
    return (slots < 2) ? 1 : $clog2(slots);
  endfunction

endpackage

// File: rtl/rom_req_sched_dem_chan.sv
// One on-demand request channel: ncs edge detect, request handshake, ack timeout/retry.
module dem_chan
  import rom_req_sched_pkg::*;
#(
  parameter int unsigned TMO = 255
) (
  input  logic clk_sys,
  input  logic nRESET,
  input  logic dem_ncs,
  input  logic dem_ack,
  input  logic grant,
  output logic pend_c,
  output logic dem_req,
  output logic dem_busy,
  output logic dem_tmo
);

  localparam int unsigned CW = (TMO < 2) ? 1 : $clog2(TMO);

  dem_state_t    state_q, state_nxt;
  logic          ncs_prev_q;
  logic          armed_q;
  logic          rereq_q, rereq_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          req_nxt, tmo_nxt;
  logic          fall_c;

  // armed_q blocks a spurious edge when ncs is already low coming out of reset
  assign fall_c = ncs_prev_q & ~dem_ncs & armed_q;
  assign pend_c = (state_q == ST_PEND);

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= ST_IDLE;
      ncs_prev_q <= 1'b1;
      armed_q    <= 1'b0;
      rereq_q    <= 1'b0;
      cnt_q      <= '0;
      dem_req    <= 1'b0;
      dem_tmo    <= 1'b0;
      dem_busy   <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      ncs_prev_q <= dem_ncs;
      armed_q    <= armed_q | dem_ncs;
      rereq_q    <= rereq_nxt;
      cnt_q      <= cnt_nxt;
      dem_req    <= req_nxt;
      dem_tmo    <= tmo_nxt;
      dem_busy   <= (state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    state_nxt = state_q;
    rereq_nxt = rereq_q;
    cnt_nxt   = cnt_q;
    req_nxt   = 1'b0;
    tmo_nxt   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall_c) state_nxt = ST_PEND;
      end
      ST_PEND: begin
        // a released chip select cancels even when the slot is available
        if (dem_ncs) begin
          state_nxt = ST_IDLE;
        end else if (grant) begin
          state_nxt = ST_WAIT;
          req_nxt   = 1'b1;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT: begin
        if (fall_c) rereq_nxt = 1'b1;
        if (dem_ack) begin
          if (rereq_q | fall_c) begin
            state_nxt = ST_PEND;
            rereq_nxt = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (cnt_q == CW'(TMO - 1)) begin
          state_nxt = ST_PEND;
          tmo_nxt   = 1'b1;
          rereq_nxt = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/rom_req_sched.sv
// Slot ring with fixed-phase strobes and priority-granted on-demand channels.
module rom_req_sched
  import rom_req_sched_pkg::*;
#(
  parameter int unsigned                     SLOTS  = 32,
  parameter int unsigned                     NCH    = 2,
  parameter logic [NCH*slot_w(SLOTS)-1:0]    PHASES = {5'd16, 5'd2},
  parameter int unsigned                     NDEM   = 1,
  parameter int unsigned                     TMO    = 255
) (
  input  logic                       clk_sys,
  input  logic                       nRESET,
  input  logic                       en,
  output logic [slot_w(SLOTS)-1:0]   slot,
  output logic [NCH-1:0]             fix_req,
  input  logic [NDEM-1:0]            dem_ncs,
  input  logic [NDEM-1:0]            dem_ack,
  output logic [NDEM-1:0]            dem_req,
  output logic [NDEM-1:0]            dem_busy,
  output logic [NDEM-1:0]            dem_tmo
);

  localparam int unsigned SW = slot_w(SLOTS);

  logic [SW-1:0]   slot_inc_c;
  logic            slot_free_c;
  logic [NDEM-1:0] pend_c;
  logic [NDEM-1:0] grant_c;

  assign slot_inc_c = (slot == SW'(SLOTS - 1)) ? '0 : slot + SW'(1);

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) slot <= '0;
    else if (en) slot <= slot_inc_c;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_fix
    assign fix_req[g] = en & (slot == PHASES[g*SW +: SW]);
  end

  // A demand request issued now lands on slot+1, which must not collide with a fixed phase
  always_comb begin
    slot_free_c = 1'b1;
    for (int i = 0; i < int'(NCH); i++) begin
      if (PHASES[i*SW +: SW] == slot_inc_c) slot_free_c = 1'b0;
    end
  end

  always_comb begin : grant_blk
    logic blocked;
    blocked = 1'b0;
    grant_c = '0;
    for (int i = 0; i < int'(NDEM); i++) begin
      grant_c[i] = pend_c[i] & slot_free_c & ~blocked;
      blocked    = blocked | pend_c[i];
    end
  end

  for (genvar c = 0; c < NDEM; c++) begin : g_chan
    dem_chan #(.TMO(TMO)) u_chan (
      .clk_sys  (clk_sys),
      .nRESET   (nRESET),
      .dem_ncs  (dem_ncs[c]),
      .dem_ack  (dem_ack[c]),
      .grant    (grant_c[c]),
      .pend_c   (pend_c[c]),
      .dem_req  (dem_req[c]),
      .dem_busy (dem_busy[c]),
      .dem_tmo  (dem_tmo[c])
    );
  end

endmodule

// File: doc/rom_req_sched.md
ROM_REQ_SCHED -- requirements
Module: rom_req_sched

Interface
REQ-001 Parameter SLOTS, default 32: length of the request slot ring (≥4).
REQ-002 Parameter NCH, default 2: number of fixed-phase request channels.
REQ-003 Parameter PHASES, default {5'd16, 5'd2}: packed slot index per fixed channel, NCH×SW bits (SW = clog2(SLOTS)); values distinct and < SLOTS.
REQ-004 Parameter NDEM, default 1: number of on-demand request channels.
REQ-005 Parameter TMO, default 255: cycles in WAIT without an ack before a retry.
REQ-006 clk_sys  in  1  system clock (96 MHz); the only clock.
REQ-007 nRESET  in  1  reset, asynchronous, active-low.
REQ-008 en  in  1  ring advance enable.
REQ-009 slot  out  SW  current ring position.
REQ-010 fix_req  out  NCH  fixed-channel request strobes.
REQ-011 dem_ncs  in  NDEM  per-channel active-low chip select.
REQ-012 dem_ack  in  NDEM  per-channel completion pulse from SDRAM.
REQ-013 dem_req  out  NDEM  per-channel registered request pulse.
REQ-014 dem_busy  out  NDEM  high while the channel is in PEND or WAIT; used for DTACK gating.
REQ-015 dem_tmo  out  NDEM  one-cycle pulse per timeout.

Function
REQ-016 slot SHALL increment by 1 each cycle while en=1, wrap from SLOTS-1 to 0, and hold while en=0.
REQ-017 fix_req[i] SHALL equal en AND (slot == PHASES[i]), i.e. a one-cycle strobe every SLOTS cycles.
REQ-018 Each demand channel SHALL register dem_ncs (previous-value register) and detect a falling edge as prev=1, cur=0.
REQ-019 Demand channel FSM states: IDLE, PEND, WAIT.
REQ-020 Transition IDLE→PEND SHALL occur on the cycle after a detected falling edge.
REQ-021 In PEND, a channel is granted when: (a) (slot+1) mod SLOTS matches no PHASES entry, evaluated regardless of en; and (b) no lower-indexed channel is in PEND.
REQ-022 A grant in PEND SHALL drive dem_req high for exactly the next cycle and move the channel to WAIT, clearing its timeout counter.
REQ-023 In PEND, if dem_ncs is high the channel SHALL return to IDLE without issuing a request (cancel).
REQ-024 In WAIT, dem_ack=1 SHALL move the channel to IDLE; if a re-request flag is set, it SHALL move to PEND instead and clear the flag.
REQ-025 A falling edge on dem_ncs during WAIT SHALL set the re-request flag; a rising edge during WAIT SHALL not abort the in-flight access.
REQ-026 In WAIT, the timeout counter SHALL count cycles; on reaching TMO without an ack, the channel SHALL pulse dem_tmo, go to PEND, and retry.
REQ-027 dem_ack in IDLE or PEND SHALL be ignored.
REQ-028 Demand FSMs SHALL run independently of en.
REQ-029 Simultaneous ack and timeout in the same cycle: ack wins, and no dem_tmo pulse is issued.

Reset
REQ-030 On nRESET=0: slot=0, fix_req=0 except where a PHASES entry equals 0 (then it follows en), dem_req=0, dem_tmo=0, all channels IDLE, dem_ncs previous-value registers=1, re-request flags=0, counters=0.
REQ-031 Reset asserted mid-WAIT SHALL abandon the access without any req or tmo pulse; after release, a channel with dem_ncs already low SHALL stay IDLE until a new falling edge.

Structure
REQ-032 A shared package SHALL hold the IDLE/PEND/WAIT state type and the slot-width function.
REQ-033 The per-channel FSM (edge detect, re-request flag, timeout counter) SHALL be sub-module dem_chan, instantiated NDEM times; ring, phase decode and priority grant stay in the top module.

Verification
REQ-034 Defaults, en=1 from reset release → fix_req[0] at slot 2 and fix_req[1] at slot 16, each repeating every 32 cycles; en=0 for 5 cycles → slot frozen and no strobes.
REQ-035 dem_ncs[0] falls when slot=0 → state PEND at slot 1; not granted at slot 1 (slot 2 is a phase); dem_req pulse at slot 3; dem_busy stays high until dem_ack.
REQ-036 NDEM=2, both ncs fall in the same cycle → channel 0 requests first, channel 1 one cycle later; neither request coincides with fix_req.
REQ-037 TMO=8, no ack → dem_tmo pulse after 8 WAIT cycles, then a re-issued dem_req; dem_ack arriving on the same cycle as the timeout → IDLE, no dem_tmo.
REQ-038 ncs rises while in PEND → no dem_req and dem_busy drops; a falling edge during WAIT followed by ack → a second dem_req is issued.
REQ-039 nRESET pulsed low while in WAIT with ncs held low → all outputs 0, slot=0; no dem_req after release until ncs toggles high then low.
